// File: rtl/coef_loader.sv
// Host byte-stream loader for the L/R coefficient RAM: parses write and read-back bursts
// from a valid/ready byte link and drives the RAM rw ports.
module coef_loader #(
    parameter int unsigned ADDR_W  = 14,
    parameter int unsigned DATA_W  = 36,
    parameter int unsigned NBYTES  = 5,
    parameter int unsigned TIMEOUT = 50000
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic [7:0]        i_rx_data,
    input  logic              i_rx_valid,
    output logic              o_rx_ready,
    output logic [7:0]        o_tx_data,
    output logic              o_tx_valid,
    input  logic              i_tx_ready,
    output logic [ADDR_W-1:0] o_addrLrw,
    output logic [ADDR_W-1:0] o_addrRrw,
    output logic [DATA_W-1:0] o_datainLrw,
    output logic [DATA_W-1:0] o_datainRrw,
    output logic              o_weL,
    output logic              o_weR,
    input  logic [DATA_W-1:0] i_dataoutLrw,
    input  logic [DATA_W-1:0] i_dataoutRrw,
    output logic              o_busy,
    output logic              o_done,
    output logic              o_err
);

    localparam int unsigned SW = NBYTES * 8;
    localparam int unsigned TW = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
    localparam int unsigned BW = (NBYTES > 1) ? $clog2(NBYTES) : 1;

    typedef enum logic [3:0] {
        StIdle, StHdrAh, StHdrAl, StHdrN, StWrBytes, StWrPulse,
        StRdWait, StRdCap, StRdSend, StDone
    } state_t;

    state_t            r_state;
    state_t            w_state_next;
    logic              r_rd;
    logic              r_ch;
    logic              r_err;
    logic [ADDR_W-1:0] r_addr;
    logic [7:0]        r_count;
    logic [SW-1:0]     r_shift;
    logic [BW-1:0]     r_bcnt;
    logic [TW-1:0]     r_tmo;

    logic w_rx_hs;
    logic w_tx_hs;
    logic w_last_byte;
    logic w_tmo_zone;
    logic w_tmo_hit;

    assign w_rx_hs     = i_rx_valid & o_rx_ready;
    assign w_tx_hs     = o_tx_valid & i_tx_ready;
    assign w_last_byte = (r_bcnt == BW'(NBYTES - 1));
    assign w_tmo_zone  = (r_state == StHdrAh) || (r_state == StHdrAl) ||
                         (r_state == StHdrN)  || (r_state == StWrBytes);
    // Fires on the TIMEOUT-th consecutive idle cycle inside a command.
    assign w_tmo_hit   = (TIMEOUT != 0) && w_tmo_zone && !w_rx_hs &&
                         (r_tmo == TW'(TIMEOUT - 1));

    assign o_addrLrw   = r_addr;
    assign o_addrRrw   = r_addr;
    assign o_datainLrw = r_shift[DATA_W-1:0];
    assign o_datainRrw = r_shift[DATA_W-1:0];
    assign o_err       = r_err;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        o_rx_ready   = 1'b0;
        o_tx_valid   = 1'b0;
        o_tx_data    = 8'h00;
        o_weL        = 1'b0;
        o_weR        = 1'b0;
        o_busy       = 1'b1;
        o_done       = 1'b0;
        case (r_state)
            StIdle: begin
                o_rx_ready = 1'b1;
                o_busy     = 1'b0;
                if (w_rx_hs && (i_rx_data[5:0] == 6'd0)) w_state_next = StHdrAh;
            end
            StHdrAh: begin
                o_rx_ready = 1'b1;
                if (w_rx_hs)        w_state_next = StHdrAl;
                else if (w_tmo_hit) w_state_next = StIdle;
            end
            StHdrAl: begin
                o_rx_ready = 1'b1;
                if (w_rx_hs)        w_state_next = StHdrN;
                else if (w_tmo_hit) w_state_next = StIdle;
            end
            StHdrN: begin
                o_rx_ready = 1'b1;
                if (w_rx_hs)        w_state_next = r_rd ? StRdWait : StWrBytes;
                else if (w_tmo_hit) w_state_next = StIdle;
            end
            StWrBytes: begin
                o_rx_ready = 1'b1;
                if (w_rx_hs && w_last_byte) w_state_next = StWrPulse;
                else if (w_tmo_hit)         w_state_next = StIdle;
            end
            StWrPulse: begin
                o_weL        = ~r_ch;
                o_weR        = r_ch;
                w_state_next = (r_count == 8'd0) ? StDone : StWrBytes;
            end
            StRdWait: w_state_next = StRdCap;
            StRdCap:  w_state_next = StRdSend;
            StRdSend: begin
                o_tx_valid = 1'b1;
                o_tx_data  = r_shift[SW-1 -: 8];
                if (w_tx_hs && w_last_byte) begin
                    w_state_next = (r_count == 8'd0) ? StDone : StRdWait;
                end
            end
            StDone: begin
                o_done       = 1'b1;
                w_state_next = StIdle;
            end
            default: w_state_next = StIdle;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_rd    <= 1'b0;
            r_ch    <= 1'b0;
            r_err   <= 1'b0;
            r_addr  <= '0;
            r_count <= '0;
            r_shift <= '0;
            r_bcnt  <= '0;
            r_tmo   <= '0;
        end else begin
            r_err <= w_tmo_hit;
            case (r_state)
                StIdle: begin
                    if (w_rx_hs) begin
                        r_rd  <= i_rx_data[7];
                        r_ch  <= i_rx_data[6];
                        r_err <= (i_rx_data[5:0] != 6'd0);
                    end
                end
                StHdrAh: if (w_rx_hs) r_addr[ADDR_W-1:8] <= i_rx_data[ADDR_W-9:0];
                StHdrAl: if (w_rx_hs) r_addr[7:0] <= i_rx_data;
                StHdrN: begin
                    if (w_rx_hs) begin
                        r_count <= i_rx_data;
                        r_bcnt  <= '0;
                    end
                end
                StWrBytes: begin
                    if (w_rx_hs) begin
                        r_shift <= {r_shift[SW-9:0], i_rx_data};
                        r_bcnt  <= w_last_byte ? '0 : r_bcnt + BW'(1);
                    end
                end
                StWrPulse: begin
                    r_addr  <= r_addr + ADDR_W'(1);
                    r_count <= r_count - 8'd1;
                end
                StRdCap: begin
                    r_shift <= {{(SW - DATA_W){1'b0}}, (r_ch ? i_dataoutRrw : i_dataoutLrw)};
                    r_bcnt  <= '0;
                end
                StRdSend: begin
                    if (w_tx_hs) begin
                        r_shift <= {r_shift[SW-9:0], 8'h00};
                        r_bcnt  <= w_last_byte ? '0 : r_bcnt + BW'(1);
                        if (w_last_byte) begin
                            r_addr  <= r_addr + ADDR_W'(1);
                            r_count <= r_count - 8'd1;
                        end
                    end
                end
                default: ;
            endcase
            if (!w_tmo_zone || w_rx_hs) r_tmo <= '0;
            else                        r_tmo <= r_tmo + TW'(1);
        end
    end

endmodule

// File: tb/tb_coef_loader.sv
// Directed bench for coef_loader: write/read bursts, address wrap, bad command, timeout,
// mid-read reset and back-to-back commands with rx_valid held high.
module tb_coef_loader;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        rx_ready;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready;
    logic [13:0] addr_l, addr_r;
    logic [35:0] din_l, din_r, dout_l, dout_r;
    logic        we_l, we_r, busy, done, err;

    int n_cmp = 0;
    int n_bad = 0;
    int done_cnt = 0;
    int err_cnt = 0;
    bit hold_valid = 1'b0;
    logic [51:0] wq[$];

    logic [35:0] ram_l [0:16383];
    logic [35:0] ram_r [0:16383];
    logic        pre_we;
    logic        pre_ch;
    logic [13:0] pre_addr;
    logic [35:0] pre_data;

    logic [7:0] exp2 [10] = '{8'h09, 8'h87, 8'h65, 8'h43, 8'h21,
                              8'h0C, 8'h12, 8'h34, 8'h56, 8'h78};

    always #5 clk = ~clk;

    coef_loader #(.TIMEOUT(100)) dut (
        .i_clk        (clk),
        .i_rst_n      (rst_n),
        .i_rx_data    (rx_data),
        .i_rx_valid   (rx_valid),
        .o_rx_ready   (rx_ready),
        .o_tx_data    (tx_data),
        .o_tx_valid   (tx_valid),
        .i_tx_ready   (tx_ready),
        .o_addrLrw    (addr_l),
        .o_addrRrw    (addr_r),
        .o_datainLrw  (din_l),
        .o_datainRrw  (din_r),
        .o_weL        (we_l),
        .o_weR        (we_r),
        .i_dataoutLrw (dout_l),
        .i_dataoutRrw (dout_r),
        .o_busy       (busy),
        .o_done       (done),
        .o_err        (err)
    );

    // Synchronous-read RAM model with a bench preload port.
    always @(posedge clk) begin
        if (we_l) ram_l[addr_l] <= din_l;
        if (we_r) ram_r[addr_r] <= din_r;
        if (pre_we && !pre_ch) ram_l[pre_addr] <= pre_data;
        if (pre_we && pre_ch)  ram_r[pre_addr] <= pre_data;
        dout_l <= ram_l[addr_l];
        dout_r <= ram_r[addr_r];
    end

    always @(negedge clk) begin
        if (done) done_cnt <= done_cnt + 1;
        if (err)  err_cnt  <= err_cnt + 1;
        if (we_l || we_r) wq.push_back({we_r, we_l, addr_l, din_l});
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got running expected finished");
        $fatal(1);
    end

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic preload(input logic ch, input logic [13:0] a, input logic [35:0] d);
        pre_we = 1'b1; pre_ch = ch; pre_addr = a; pre_data = d;
        @(negedge clk);
        pre_we = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b);
        bit ok;
        ok = 1'b0;
        rx_data  = b;
        rx_valid = 1'b1;
        for (int k = 0; k < 300; k++) begin
            if (rx_ready) begin
                @(negedge clk);
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        if (!ok) check_eq("rx_handshake_timeout", 64'd0, 64'd1);
        if (!hold_valid) rx_valid = 1'b0;
    endtask

    task automatic send4(input logic [7:0] a, input logic [7:0] b, input logic [7:0] c,
                         input logic [7:0] d);
        send_byte(a); send_byte(b); send_byte(c); send_byte(d);
    endtask

    task automatic recv_byte(input bit stall, input string tag, output logic [7:0] b);
        bit got;
        logic [7:0] held;
        got = 1'b0;
        b = 8'h00;
        for (int k = 0; k < 300; k++) begin
            if (tx_valid) begin
                if (stall) begin
                    tx_ready = 1'b0;
                    held = tx_data;
                    @(negedge clk);
                    check_eq({tag, "_stall_valid"}, tx_valid, 1);
                    check_eq({tag, "_stall_data"}, tx_data, held);
                end
                tx_ready = 1'b1;
                b = tx_data;
                @(negedge clk);
                tx_ready = 1'b0;
                got = 1'b1;
                break;
            end
            @(negedge clk);
        end
        if (!got) check_eq({tag, "_tx_timeout"}, 64'd0, 64'd1);
    endtask

    function automatic logic [35:0] t6_word(input int i);
        return {4'(i), 8'(32'hD0 | i), 8'h5A, 8'(i * 3), 8'(32'hE0 ^ i)};
    endfunction

    initial begin
        logic [7:0]  b;
        logic [35:0] w;
        logic [39:0] p;
        int          lat;

        rst_n = 1'b0; rx_valid = 1'b0; rx_data = 8'h00; tx_ready = 1'b0; pre_we = 1'b0;
        pre_ch = 1'b0; pre_addr = '0; pre_data = '0;
        repeat (2) @(negedge clk);
        check_eq("rst_rx_ready", rx_ready, 1);
        check_eq("rst_tx_valid", tx_valid, 0);
        check_eq("rst_tx_data", tx_data, 0);
        check_eq("rst_busy", busy, 0);
        check_eq("rst_done", done, 0);
        check_eq("rst_err", err, 0);
        check_eq("rst_we", {we_l, we_r}, 0);
        check_eq("rst_addr", addr_l, 0);
        check_eq("rst_datain", din_l, 0);
        rst_n = 1'b1;
        @(negedge clk);

        // 1: write L burst of two words at address 5
        send4(8'h00, 8'h00, 8'h05, 8'h01);
        send4(8'h01, 8'h23, 8'h45, 8'h67);
        send_byte(8'h89);
        check_eq("t1_we_l_latency", we_l, 1);
        check_eq("t1_we_r_quiet", we_r, 0);
        check_eq("t1_we_addr", addr_l, 14'd5);
        check_eq("t1_we_data", din_l, 36'h123456789);
        send4(8'hFA, 8'hBC, 8'hDE, 8'hF0);
        send_byte(8'h12);
        repeat (4) @(negedge clk);
        check_eq("t1_nwrites", wq.size(), 2);
        check_eq("t1_wr0", wq[0], {2'b01, 14'd5, 36'h123456789});
        check_eq("t1_wr1", wq[1], {2'b01, 14'd6, 36'hABCDEF012});
        check_eq("t1_done", done_cnt, 1);
        check_eq("t1_busy", busy, 0);

        // 2: read R across the address wrap with tx_ready stalls
        preload(1'b1, 14'h3FFF, 36'h987654321);
        preload(1'b1, 14'h0000, 36'hC12345678);
        preload(1'b0, 14'h3FFF, 36'h555555555);
        preload(1'b0, 14'h0000, 36'hAAAAAAAAA);
        send4(8'hC0, 8'h3F, 8'hFF, 8'h01);
        check_eq("t2_txv_cycle1", tx_valid, 0);
        check_eq("t2_busy", busy, 1);
        @(negedge clk);
        check_eq("t2_txv_cycle2", tx_valid, 0);
        @(negedge clk);
        check_eq("t2_txv_cycle3", tx_valid, 1);
        for (int j = 0; j < 10; j++) begin
            recv_byte(1'b1, "t2", b);
            check_eq($sformatf("t2_byte%0d", j), b, exp2[j]);
        end
        repeat (4) @(negedge clk);
        check_eq("t2_done", done_cnt, 2);
        check_eq("t2_tx_idle", tx_valid, 0);

        // 3: bad command byte, then a normal write at address 0
        wq.delete();
        send_byte(8'h21);
        check_eq("t3_err", err, 1);
        check_eq("t3_busy", busy, 0);
        @(negedge clk);
        check_eq("t3_err_pulse", err, 0);
        send4(8'h00, 8'h00, 8'h00, 8'h00);
        send4(8'h01, 8'h11, 8'h22, 8'h33);
        send_byte(8'h44);
        repeat (4) @(negedge clk);
        check_eq("t3_nwrites", wq.size(), 1);
        check_eq("t3_wr0", wq[0], {2'b01, 14'd0, 36'h111223344});
        check_eq("t3_errs", err_cnt, 1);
        check_eq("t3_done", done_cnt, 3);

        // 4: header plus three data bytes then silence
        wq.delete();
        send4(8'h00, 8'h00, 8'h10, 8'h00);
        send_byte(8'h01); send_byte(8'h02); send_byte(8'h03);
        lat = 0;
        for (int k = 1; k <= 150; k++) begin
            @(negedge clk);
            if (err) begin
                lat = k;
                break;
            end
        end
        check_eq("t4_timeout_cycles", lat, 100);
        check_eq("t4_busy", busy, 0);
        check_eq("t4_rx_ready", rx_ready, 1);
        repeat (3) @(negedge clk);
        check_eq("t4_nwrites", wq.size(), 0);
        check_eq("t4_errs", err_cnt, 2);

        // 5: reset in the middle of a read, then the same read in full
        preload(1'b0, 14'h0020, 36'h701020304);
        send4(8'h80, 8'h00, 8'h20, 8'h00);
        recv_byte(1'b0, "t5a", b);
        check_eq("t5a_byte0", b, 8'h07);
        recv_byte(1'b0, "t5a", b);
        check_eq("t5a_byte1", b, 8'h01);
        for (int k = 0; k < 20 && !tx_valid; k++) @(negedge clk);
        check_eq("t5_byte2_valid", tx_valid, 1);
        rst_n = 1'b0;
        #1;
        check_eq("t5_rst_tx_valid", tx_valid, 0);
        check_eq("t5_rst_busy", busy, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check_eq("t5_no_done", done_cnt, 3);
        send4(8'h80, 8'h00, 8'h20, 8'h00);
        for (int j = 0; j < 5; j++) begin
            p = {4'h0, 36'h701020304};
            recv_byte(1'b0, "t5b", b);
            check_eq($sformatf("t5b_byte%0d", j), b, p[39 - 8 * j -: 8]);
        end
        repeat (4) @(negedge clk);
        check_eq("t5_done", done_cnt, 4);

        // 6: 16-word write at 0x1000 and read-back with rx_valid held high
        wq.delete();
        hold_valid = 1'b1;
        send4(8'h00, 8'hD0, 8'h00, 8'h0F);
        for (int i = 0; i < 16; i++) begin
            w = t6_word(i);
            send_byte({4'hF, w[35:32]});
            send4(w[31:24], w[23:16], w[15:8], w[7:0]);
        end
        send4(8'h80, 8'h10, 8'h00, 8'h0F);
        hold_valid = 1'b0;
        rx_valid = 1'b0;
        for (int i = 0; i < 16; i++) begin
            p = {4'h0, t6_word(i)};
            for (int j = 0; j < 5; j++) begin
                recv_byte(1'b0, "t6", b);
                check_eq($sformatf("t6_w%0d_b%0d", i, j), b, p[39 - 8 * j -: 8]);
            end
        end
        repeat (4) @(negedge clk);
        check_eq("t6_nwrites", wq.size(), 16);
        for (int i = 0; i < 16; i++) begin
            check_eq($sformatf("t6_wr%0d", i), wq[i], {2'b01, 14'(14'h1000 + i), t6_word(i)});
        end
        check_eq("t6_done", done_cnt, 6);
        check_eq("t6_errs", err_cnt, 2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
